// File: rtl/ct_sysio_mtime_gen_if.sv
// Software load port for the machine-time generator: split lo/hi 32-bit writes
// with a one-cycle acknowledge.
interface ct_sysio_mtime_gen_if;
  logic        load_vld;
  logic        load_hi;
  logic [31:0] load_data;
  logic        load_ack;

  modport master (
    output load_vld,
    output load_hi,
    output load_data,
    input  load_ack
  );

  modport slave (
    input  load_vld,
    input  load_hi,
    input  load_data,
    output load_ack
  );
endinterface

// File: rtl/ct_sysio_mtime_gen.sv
// 64-bit machine-time generator feeding the CLINT: programmable prescaler,
// atomic lo/hi software load, and debug-halt freeze.
module ct_sysio_mtime_gen #(
  parameter int DIV_W   = 16,
  parameter int RST_DIV = 0
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst,
  input  logic [DIV_W-1:0] div_cfg,
  input  logic             div_cfg_vld,
  input  logic             dbg_halt,
  ct_sysio_mtime_gen_if.slave ld,
  output logic             mtime_tick,
  output logic [63:0]      sysio_clint_mtime
);

  localparam logic [DIV_W-1:0] RST_DIV_W = DIV_W'(RST_DIV);

  logic [DIV_W-1:0] prescaler;
  logic [DIV_W-1:0] eff_div;
  logic [31:0]      shadow_lo;
  logic [63:0]      mtime;
  logic             load_ack;
  logic             commit;
  logic             lo_write;

  assign eff_div  = div_cfg_vld ? div_cfg : RST_DIV_W;
  assign lo_write = ld.load_vld & ~ld.load_hi;
  assign commit   = ld.load_vld &  ld.load_hi;

  // The >= compare lets a lowered divide end the current period immediately
  // instead of letting the prescaler run on to wrap.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      mtime      <= '0;
      prescaler  <= '0;
      shadow_lo  <= '0;
      load_ack   <= 1'b0;
      mtime_tick <= 1'b0;
    end else begin
      load_ack   <= ld.load_vld;
      mtime_tick <= 1'b0;
      if (lo_write) begin
        shadow_lo <= ld.load_data;
      end
      if (commit) begin
        // A commit drops any coincident tick and restarts the period.
        mtime     <= {ld.load_data, shadow_lo};
        prescaler <= '0;
      end else if (!dbg_halt) begin
        if (prescaler >= eff_div) begin
          prescaler  <= '0;
          mtime      <= mtime + 64'd1;
          mtime_tick <= 1'b1;
        end else begin
          prescaler <= prescaler + 1'b1;
        end
      end
    end
  end

  assign sysio_clint_mtime = mtime;
  assign ld.load_ack       = load_ack;

endmodule

// File: tb/tb_ct_sysio_mtime_gen.sv
// Directed bench for ct_sysio_mtime_gen: hand-computed expectations for
// counting, divide changes, load/commit, wrap, halt and reset.
module tb_ct_sysio_mtime_gen;

  logic        forever_cpuclk = 1'b0;
  logic        cpurst;
  logic [15:0] div_cfg;
  logic        div_cfg_vld;
  logic        dbg_halt;
  logic        mtime_tick;
  logic [63:0] sysio_clint_mtime;

  int n_vec = 0;
  int n_err = 0;

  ct_sysio_mtime_gen_if ld ();

  ct_sysio_mtime_gen #(.DIV_W(16), .RST_DIV(0)) dut (
    .forever_cpuclk    (forever_cpuclk),
    .cpurst            (cpurst),
    .div_cfg           (div_cfg),
    .div_cfg_vld       (div_cfg_vld),
    .dbg_halt          (dbg_halt),
    .ld                (ld.slave),
    .mtime_tick        (mtime_tick),
    .sysio_clint_mtime (sysio_clint_mtime)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge forever_cpuclk);
    #1;
  endtask

  task automatic strobe(input logic hi, input logic [31:0] data);
    ld.load_vld  = 1'b1;
    ld.load_hi   = hi;
    ld.load_data = data;
    step();
    ld.load_vld  = 1'b0;
    ld.load_hi   = 1'b0;
    ld.load_data = '0;
  endtask

  task automatic chk_out(input string tag, input logic [63:0] mt, input logic tk, input logic ak);
    chk({tag, ".mtime"}, sysio_clint_mtime, mt);
    chk({tag, ".tick"}, {63'd0, mtime_tick}, {63'd0, tk});
    chk({tag, ".ack"}, {63'd0, ld.load_ack}, {63'd0, ak});
  endtask

  task automatic do_reset();
    cpurst = 1'b1;
    step();
    chk_out("reset", 64'd0, 1'b0, 1'b0);
    cpurst = 1'b0;
  endtask

  initial begin
    cpurst       = 1'b1;
    div_cfg      = 16'd5;
    div_cfg_vld  = 1'b0;
    dbg_halt     = 1'b0;
    ld.load_vld  = 1'b0;
    ld.load_hi   = 1'b0;
    ld.load_data = '0;
    step();

    // Default divide (RST_DIV=0) ignores div_cfg while div_cfg_vld is low.
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      step();
      chk_out($sformatf("div0_c%0d", i), 64'(i), 1'b1, 1'b0);
    end

    // Divide by 4, then lower the divide mid-period.
    do_reset();
    div_cfg     = 16'd3;
    div_cfg_vld = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk_out($sformatf("div3_c%0d", i), 64'(i / 4), (i % 4) == 0, 1'b0);
    end
    step();
    step();
    chk_out("div3_p2", 64'd3, 1'b0, 1'b0);
    div_cfg = 16'd1;
    step();
    chk_out("div1_early", 64'd4, 1'b1, 1'b0);
    step();
    chk_out("div1_mid", 64'd4, 1'b0, 1'b0);
    step();
    chk_out("div1_next", 64'd5, 1'b1, 1'b0);

    // Load near the top and wrap.
    do_reset();
    div_cfg_vld = 1'b0;
    strobe(1'b0, 32'hFFFF_FFFE);
    chk_out("wrap_lo", 64'd1, 1'b1, 1'b1);
    strobe(1'b1, 32'hFFFF_FFFF);
    chk_out("wrap_commit", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1);
    step();
    chk_out("wrap_max", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    step();
    chk_out("wrap_zero", 64'd0, 1'b1, 1'b0);

    // Commit coincident with a terminal tick: tick dropped, prescaler cleared.
    do_reset();
    div_cfg     = 16'd3;
    div_cfg_vld = 1'b1;
    strobe(1'b0, 32'h0000_0010);
    step();
    step();
    chk_out("coll_pre", 64'd0, 1'b0, 1'b0);
    strobe(1'b1, 32'h0000_0001);
    chk_out("coll_commit", 64'h1_0000_0010, 1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk_out($sformatf("coll_wait%0d", i), 64'h1_0000_0010, 1'b0, 1'b0);
    end
    step();
    chk_out("coll_tick", 64'h1_0000_0011, 1'b1, 1'b0);

    // Halt at mtime=7, prescaler=2.
    do_reset();
    strobe(1'b0, 32'd7);
    strobe(1'b1, 32'd0);
    chk_out("halt_load", 64'd7, 1'b0, 1'b1);
    step();
    step();
    dbg_halt = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk_out($sformatf("halt_c%0d", i), 64'd7, 1'b0, 1'b0);
    end
    dbg_halt = 1'b0;
    step();
    chk_out("halt_rel1", 64'd7, 1'b0, 1'b0);
    step();
    chk_out("halt_rel2", 64'd8, 1'b1, 1'b0);
    dbg_halt = 1'b1;
    strobe(1'b0, 32'h20);
    chk_out("halt_lo", 64'd8, 1'b0, 1'b1);
    strobe(1'b1, 32'h0);
    chk_out("halt_commit", 64'h20, 1'b0, 1'b1);
    step();
    chk_out("halt_hold", 64'h20, 1'b0, 1'b0);
    dbg_halt = 1'b0;

    // Reset with a lo write pending discards shadow and ack.
    div_cfg_vld = 1'b0;
    strobe(1'b0, 32'h55);
    strobe(1'b1, 32'h0);
    chk_out("rst_pre", 64'h55, 1'b0, 1'b1);
    cpurst = 1'b1;
    strobe(1'b0, 32'hABCD);
    chk_out("rst_mid", 64'd0, 1'b0, 1'b0);
    cpurst = 1'b0;
    strobe(1'b1, 32'h1);
    chk_out("rst_hi", 64'h1_0000_0000, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
